// File: rtl/alarm_buzzer.sv
// Alarm buzzer: turns the alarm-active level into a beeping square-wave buzzer drive.
// Snooze support is compiled in when ALARM_BUZZER_SNOOZE_EN is defined.
module alarm_buzzer #(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned TONE_HALF   = 113636,
  parameter int unsigned BEEP_ON_MS  = 500,
  parameter int unsigned BEEP_OFF_MS = 500,
  parameter int unsigned TIMEOUT_MS  = 60000,
  parameter int unsigned SNOOZE_MS   = 300000,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic alarm_do_i,
  input  logic middle_i,
  output logic buzz_o,
  output logic ringing_o,
  output logic snoozed_o
);

  function automatic int unsigned w_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned OnOffMax = (BEEP_ON_MS > BEEP_OFF_MS) ? BEEP_ON_MS : BEEP_OFF_MS;
`ifdef ALARM_BUZZER_SNOOZE_EN
  localparam int unsigned PhaseMax = (SNOOZE_MS > OnOffMax) ? SNOOZE_MS : OnOffMax;
`else
  localparam int unsigned PhaseMax = OnOffMax;
`endif
  localparam int unsigned TickW  = w_of(TICK_DIV);
  localparam int unsigned ToneW  = w_of(TONE_HALF);
  localparam int unsigned RingW  = w_of(TIMEOUT_MS);
  localparam int unsigned PhaseW = w_of(PhaseMax);

  localparam logic [TickW-1:0]  TickLast = TickW'(TICK_DIV - 1);
  localparam logic [ToneW-1:0]  ToneLast = ToneW'(TONE_HALF - 1);
  localparam logic [RingW-1:0]  RingLast = RingW'(TIMEOUT_MS - 1);
  localparam logic [PhaseW-1:0] OnLast   = PhaseW'(BEEP_ON_MS - 1);
  localparam logic [PhaseW-1:0] OffLast  = PhaseW'(BEEP_OFF_MS - 1);

  if (TICK_DIV < 2 || TONE_HALF < 1 || BEEP_ON_MS < 1 || BEEP_OFF_MS < 1 || TIMEOUT_MS < 1 ||
      SNOOZE_MS < 1 || MAX_SNOOZE < 1) begin : g_bad_params
    $error("alarm_buzzer: invalid parameter value");
  end

`ifdef ALARM_BUZZER_SNOOZE_EN
  localparam int unsigned SnzW = w_of(MAX_SNOOZE + 1);
  localparam logic [SnzW-1:0]   SnzMax  = SnzW'(MAX_SNOOZE);
  localparam logic [PhaseW-1:0] SnzLast = PhaseW'(SNOOZE_MS - 1);

  typedef enum logic [2:0] {StIdle, StRingOn, StRingOff, StSnooze, StDone} state_e;
  logic [SnzW-1:0] snz_cnt_q;
  logic            snoozed_q;
`else
  typedef enum logic [2:0] {StIdle, StRingOn, StRingOff, StDone} state_e;
`endif

  state_e            state_q;
  logic [TickW-1:0]  tick_cnt_q;
  logic [ToneW-1:0]  tone_q;
  logic [RingW-1:0]  ring_q;
  logic [PhaseW-1:0] phase_q;
  logic [PhaseW-1:0] phase_last;
  logic              buzz_q, ringing_q;
  logic              meta_q, sync_q, sync_prev_q;
  logic              ms_tick, press, ring_end, phase_end;

  // 1 ms prescaler
  assign ms_tick = (tick_cnt_q == TickLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt_q <= '0;
    end else if (ms_tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q      <= 1'b0;
      sync_q      <= 1'b0;
      sync_prev_q <= 1'b0;
    end else begin
      meta_q      <= middle_i;
      sync_q      <= meta_q;
      sync_prev_q <= sync_q;
    end
  end

  assign press = sync_q & ~sync_prev_q;

  always_comb begin
    phase_last = OffLast;
    if (state_q == StRingOn) phase_last = OnLast;
`ifdef ALARM_BUZZER_SNOOZE_EN
    if (state_q == StSnooze) phase_last = SnzLast;
`endif
  end

  assign phase_end = ms_tick && (phase_q == phase_last);
  assign ring_end  = ms_tick && (ring_q == RingLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      ring_q    <= '0;
      tone_q    <= '0;
      buzz_q    <= 1'b0;
      ringing_q <= 1'b0;
`ifdef ALARM_BUZZER_SNOOZE_EN
      snz_cnt_q <= '0;
      snoozed_q <= 1'b0;
`endif
    end else if (!alarm_do_i) begin
      // Dropping the request overrides everything and re-arms from IDLE.
      state_q   <= StIdle;
      buzz_q    <= 1'b0;
      ringing_q <= 1'b0;
`ifdef ALARM_BUZZER_SNOOZE_EN
      snz_cnt_q <= '0;
      snoozed_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q   <= StRingOn;
          phase_q   <= '0;
          ring_q    <= '0;
          tone_q    <= '0;
          buzz_q    <= 1'b0;
          ringing_q <= 1'b1;
        end
        StRingOn, StRingOff: begin
          if (ms_tick && !ring_end) ring_q <= ring_q + 1'b1;
          if (ms_tick && !phase_end) phase_q <= phase_q + 1'b1;
          if (state_q == StRingOn) begin
            if (tone_q == ToneLast) begin
              tone_q <= '0;
              buzz_q <= ~buzz_q;
            end else begin
              tone_q <= tone_q + 1'b1;
            end
          end
          // Later assignments win: timeout beats press beats the beep cadence.
          if (ring_end) begin
            state_q   <= StDone;
            buzz_q    <= 1'b0;
            ringing_q <= 1'b0;
          end else if (press) begin
            buzz_q    <= 1'b0;
            ringing_q <= 1'b0;
`ifdef ALARM_BUZZER_SNOOZE_EN
            if (snz_cnt_q != SnzMax) begin
              state_q   <= StSnooze;
              snz_cnt_q <= snz_cnt_q + 1'b1;
              snoozed_q <= 1'b1;
              phase_q   <= '0;
            end else begin
              state_q <= StDone;
            end
`else
            state_q <= StDone;
`endif
          end else if (phase_end) begin
            phase_q <= '0;
            tone_q  <= '0;
            buzz_q  <= 1'b0;
            state_q <= (state_q == StRingOn) ? StRingOff : StRingOn;
          end
        end
`ifdef ALARM_BUZZER_SNOOZE_EN
        StSnooze: begin
          if (phase_end) begin
            state_q   <= StRingOn;
            phase_q   <= '0;
            ring_q    <= '0;
            tone_q    <= '0;
            buzz_q    <= 1'b0;
            ringing_q <= 1'b1;
            snoozed_q <= 1'b0;
          end else if (ms_tick) begin
            phase_q <= phase_q + 1'b1;
          end
        end
`endif
        StDone: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign buzz_o    = buzz_q;
  assign ringing_o = ringing_q;
`ifdef ALARM_BUZZER_SNOOZE_EN
  assign snoozed_o = snoozed_q;
`else
  assign snoozed_o = 1'b0;
`endif

endmodule
